// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift one
// command byte out on device-generated clocks, check the device ACK.
// Both bus lines are driven open-drain through active-high pull-low enables.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 6000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clock50,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES) + 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_SEND,
      S_ACK_WAIT,
      S_WAIT_IDLE
   } state_t;

   state_t            state;
   logic              clk_meta;
   logic              clk_s;
   logic              clk_prev;
   logic              dat_meta;
   logic              dat_s;
   logic              fall;
   logic [7:0]        shreg;
   logic              parity;
   logic [3:0]        bit_cnt;
   logic [INH_W-1:0]  inh_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [TO_W-1:0]   to_next;
   logic              timeout;

   // Two-flop synchronizers for the raw pins plus a delayed clock for edge detect
   always_ff @(posedge clock50) begin
      if (reset) begin
         clk_meta <= 1'b1;
         clk_s    <= 1'b1;
         clk_prev <= 1'b1;
         dat_meta <= 1'b1;
         dat_s    <= 1'b1;
      end else begin
         clk_meta <= ps2_clk_in;
         clk_s    <= clk_meta;
         clk_prev <= clk_s;
         dat_meta <= ps2_dat_in;
         dat_s    <= dat_meta;
      end
   end

   // Falling edge of the synchronized device clock and timeout compare
   always_comb begin
      fall    = clk_prev & ~clk_s;
      to_next = to_cnt + 1'b1;
      timeout = (to_next == TO_W'(TIMEOUT_CYCLES));
   end

   // Transmit sequencer with registered bus enables and status pulses
   always_ff @(posedge clock50) begin
      if (reset) begin
         state      <= S_IDLE;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
         tx_error   <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         shreg      <= '0;
         parity     <= 1'b0;
         bit_cnt    <= '0;
         inh_cnt    <= '0;
         to_cnt     <= '0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         case (state)
            S_IDLE: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               if (tx_start) begin
                  shreg      <= tx_data;
                  parity     <= ~^tx_data;
                  tx_busy    <= 1'b1;
                  ps2_clk_oe <= 1'b1;
                  inh_cnt    <= '0;
                  state      <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                  ps2_dat_oe <= 1'b1;
                  state      <= S_RTS;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end
            S_RTS: begin
               // start bit stays pulled low; releasing the clock hands it to the device
               ps2_clk_oe <= 1'b0;
               bit_cnt    <= '0;
               to_cnt     <= '0;
               state      <= S_SEND;
            end
            S_SEND, S_ACK_WAIT, S_WAIT_IDLE: begin
               to_cnt <= to_next;
               if (timeout) begin
                  tx_error   <= 1'b1;
                  tx_busy    <= 1'b0;
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  state      <= S_IDLE;
               end else if (state == S_SEND) begin
                  if (fall) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt < 4'd8) begin
                        ps2_dat_oe <= ~shreg[bit_cnt[2:0]];
                     end else if (bit_cnt == 4'd8) begin
                        ps2_dat_oe <= ~parity;
                     end else begin
                        ps2_dat_oe <= 1'b0;
                        state      <= S_ACK_WAIT;
                     end
                  end
               end else if (state == S_ACK_WAIT) begin
                  if (fall) begin
                     if (!dat_s) begin
                        state <= S_WAIT_IDLE;
                     end else begin
                        tx_error <= 1'b1;
                        tx_busy  <= 1'b0;
                        state    <= S_IDLE;
                     end
                  end
               end else begin
                  if (clk_s && dat_s) begin
                     tx_done <= 1'b1;
                     tx_busy <= 1'b0;
                     state   <= S_IDLE;
                  end
               end
            end
            default: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               tx_busy    <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx with a behavioural PS/2 device.
module tb_ps2_host_tx;

   localparam int unsigned INH  = 20;
   localparam int unsigned TMO  = 5000;
   localparam int unsigned HALF = 20;

   localparam int M_ACK    = 0;
   localparam int M_NOACK  = 1;
   localparam int M_NOCLK  = 2;
   localparam int M_INJECT = 3;
   localparam int M_RESET  = 4;

   logic       clock50 = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_start = 1'b0;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       model_clk = 1'b1;
   logic       model_dat = 1'b1;

   // Open-drain bus: a line is low if either side pulls it
   assign ps2_clk_in = model_clk & ~ps2_clk_oe;
   assign ps2_dat_in = model_dat & ~ps2_dat_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock50   (clock50),
      .reset     (reset),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .tx_error  (tx_error),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe)
   );

   // 50 MHz system clock
   always #10 clock50 = ~clock50;

   typedef struct packed {
      logic        is_err;
      logic [10:0] frame;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [10:0] rx_frame = '0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(negedge clock50);
   endtask

   // Expected line frame: start(0), 8 data bits LSB first, odd parity, stop(1)
   function automatic logic [10:0] ref_frame(input logic [7:0] d);
      int   ones;
      logic par;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      par = ((ones % 2) == 0);
      return {1'b1, par, d, 1'b0};
   endfunction

   // Monitor: every done/error pulse is matched against the scoreboard queue
   always @(negedge clock50) begin
      if (tx_done || tx_error) begin
         check("done_error_exclusive", {31'b0, tx_done & tx_error}, 32'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: done=%b error=%b required no pulse", tx_done, tx_error);
         end else begin
            mon_e = exp_q.pop_front();
            check("result_kind_error", {31'b0, tx_error}, {31'b0, mon_e.is_err});
            if (!mon_e.is_err && tx_done)
               check("frame_bits", {21'b0, rx_frame}, {21'b0, mon_e.frame});
         end
      end
   end

   // One host transaction with the device model behaving according to mode
   task automatic run_frame(input logic [7:0] d, input int mode);
      int   cnt;
      int   rise_at;
      int   n;
      exp_t e;
      tick();
      tx_data  = d;
      tx_start = 1'b1;
      if (mode != M_RESET) begin
         e.is_err = (mode == M_NOACK) || (mode == M_NOCLK);
         e.frame  = ref_frame(d);
         exp_q.push_back(e);
      end
      tick();
      tx_start = 1'b0;
      check("busy_after_accept", {31'b0, tx_busy}, 32'd1);
      cnt = 0;
      rise_at = 0;
      while (ps2_clk_oe && cnt < int'(INH) + 50) begin
         cnt++;
         if (ps2_dat_oe && rise_at == 0) rise_at = cnt;
         tick();
      end
      check("clk_oe_low_cycles", cnt, INH + 1);
      check("dat_oe_rise_cycle", rise_at, INH + 1);
      check("start_bit_held", {31'b0, ps2_dat_oe}, 32'd1);

      if (mode == M_NOCLK) begin
         n = 0;
         while (!tx_error && n < int'(TMO) + 100) begin
            tick();
            n++;
         end
         check("timeout_latency", n, TMO);
         check("busy_low_with_error", {31'b0, tx_busy}, 32'd0);
         tick();
         check("lines_released_timeout", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
         check("scoreboard_drained", exp_q.size(), 32'd0);
         return;
      end

      repeat (5) tick();
      for (int i = 1; i <= 11; i++) begin
         if (i == 1) rx_frame[0] = ps2_dat_in;
         model_clk = 1'b0;
         if (mode == M_RESET && i == 4) begin
            repeat (5) tick();
            reset = 1'b1;
            tick();
            check("reset_midframe_outputs",
                  {27'b0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 32'd0);
            reset     = 1'b0;
            model_clk = 1'b1;
            repeat (10) tick();
            check("reset_midframe_idle", {31'b0, tx_busy}, 32'd0);
            return;
         end
         if (mode == M_INJECT && i == 3) begin
            tick();
            tx_data  = 8'hFF;
            tx_start = 1'b1;
            tick();
            tx_start = 1'b0;
            repeat (HALF - 2) tick();
         end else begin
            repeat (HALF) tick();
         end
         model_clk = 1'b1;
         if (i <= 10) rx_frame[i] = ps2_dat_in;
         repeat (HALF / 2) tick();
         if (i == 10 && mode != M_NOACK) model_dat = 1'b0;
         if (i == 11) model_dat = 1'b1;
         repeat (HALF / 2) tick();
      end
      n = 0;
      while (tx_busy && n < 200) begin
         tick();
         n++;
      end
      check("busy_released", {31'b0, tx_busy}, 32'd0);
      tick();
      check("lines_released", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      check("scoreboard_drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) tick();
      check("reset_outputs", {27'b0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      reset = 1'b0;
      repeat (3) tick();
      check("idle_outputs", {27'b0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 32'd0);

      run_frame(8'hED, M_ACK);
      run_frame(8'h01, M_ACK);
      run_frame(8'h00, M_ACK);
      run_frame(8'($urandom_range(0, 255)), M_NOACK);
      run_frame(8'hA5, M_NOCLK);
      run_frame(8'hED, M_INJECT);
      run_frame(8'h3C, M_RESET);
      run_frame(8'hF4, M_ACK);
      for (int k = 0; k < 4; k++) run_frame(8'($urandom_range(0, 255)), M_ACK);

      repeat (20) tick();
      check("final_scoreboard_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Guard against a stuck run
   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same PS2_CLK/PS2_DAT lines that the keyboard receive path listens on.
- Drives both lines open-drain through active-high pull-low enables. The top level does `PS2_x = oe ? 1'b0 : 1'bz`.
- Performs the inhibit / request-to-send sequence, shifts the frame out on device-generated clocks, checks the device ACK, and reports done or error.

Parameters:
- INHIBIT_CYCLES, 6000, clock50 cycles the host holds PS2_CLK low before request-to-send (120 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum clock50 cycles from the SEND state to completion (15 ms) before an error is flagged.

Ports:
- clock50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte; sampled when tx_start is accepted.
- tx_start  in  1  1-cycle request; accepted only in IDLE.
- tx_busy  out  1  high from the cycle after acceptance until return to IDLE.
- tx_done  out  1  1-cycle pulse: frame sent and device ACK received.
- tx_error  out  1  1-cycle pulse: missing ACK or timeout.
- ps2_clk_in  in  1  raw PS2_CLK pin (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.

Behaviour:
- Reset: state=IDLE; tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe all 0; counters cleared; synchronizer flops set to 1 (idle bus). Reset mid-frame releases both lines on the next clock50 edge.
- Input sync: each of ps2_clk_in and ps2_dat_in passes through 2 flops, giving clk_s and dat_s.
- Falling-edge detect: clk_prev is clk_s delayed one cycle. fall = clk_prev & ~clk_s.
- Acceptance: on acceptance, latch tx_data into shreg[7:0] and latch parity = ~^tx_data (odd parity). tx_start outside IDLE is ignored, and the latched data is unchanged.
- IDLE: both oe = 0. If tx_start, go to INHIBIT next cycle.
- INHIBIT: clk_oe=1, dat_oe=0, for exactly INHIBIT_CYCLES cycles, then RTS.
- RTS (1 cycle): clk_oe=1, dat_oe=1 (start bit, data pulled low while clock is still held). Then SEND with bit_cnt=0 and the timeout counter cleared.
- SEND: clk_oe=0, so the device generates the clock. On each fall, dat_oe takes the next frame bit, where oe = ~bit:
  - bit_cnt 0..7: data bit bit_cnt, LSB first.
  - bit_cnt 8: parity.
  - bit_cnt 9: stop; dat_oe=0.
  - bit_cnt increments on each fall. After the fall with bit_cnt=9, go to ACK_WAIT.
- ACK_WAIT: both oe = 0. On the next fall, sample dat_s. If 0 (ACK), go to WAIT_IDLE. If 1, pulse tx_error and go to IDLE.
- WAIT_IDLE: when clk_s=1 and dat_s=1 in the same cycle, pulse tx_done and go to IDLE.
- Timeout: the counter increments every cycle in SEND, ACK_WAIT and WAIT_IDLE. When it reaches TIMEOUT_CYCLES: pulse tx_error, set both oe=0, go to IDLE. Timeout has priority over a coincident fall or done.
- Exclusivity: tx_done and tx_error are never high in the same cycle.
- tx_busy: low in the same cycle as the done/error pulse, i.e. the state is already IDLE on the following cycle. A new tx_start is accepted in that IDLE cycle.
- Counter widths: $clog2 of the respective parameter + 1. bit_cnt is 4 bits.
- Datapath: no combinational path from ps2_*_in to any output. oe outputs are registered.

Test Plan:
- INHIBIT_CYCLES=20, TIMEOUT_CYCLES=5000, BFM device model clocking at 40-cycle period.
  - Send 0xED.
  - Required: clk_oe high exactly 21 cycles (20 inhibit + 1 RTS), with dat_oe rising on the last of them.
  - Required: bits observed on the model's rising edges = 0,1,0,1,1,0,1,1,1 (parity=1), then stop=1.
  - Model ACKs → exactly one tx_done pulse, tx_error=0, tx_busy falls.
- Send 0x01 → parity bit 0. Send 0x00 → parity bit 1. Each ends with tx_done.
- Model withholds the ACK (data stays high on the 11th fall) → tx_error pulse, no tx_done, both oe=0 afterwards.
- Model never clocks after RTS → tx_error exactly TIMEOUT_CYCLES cycles after SEND entry; both lines released.
- tx_start with 0xFF pulsed during SEND of 0xED → ignored; the frame carries 0xED; a single tx_done.
- reset asserted after the 4th fall → next cycle both oe=0, tx_busy=0, no done/error pulse. A subsequent tx_start with 0xF4 completes normally.
